// File: rtl/btn_step_counter.sv
// btn_step_counter: debounced up/down/clear button counter, single clock.
// Ports: sysclk, reset_n (async, active-low), btn_up/btn_down/btn_clr (raw),
//        count[WIDTH], step_pulse, limit_pulse (all outputs registered).
// Optional auto-repeat: define BTN_STEP_COUNTER_AUTOREPEAT_EN
//   (uses HOLD_CYCLES >= 2 and REPEAT_CYCLES >= 2).
module btn_step_counter #(
  parameter int WIDTH                    = 4,
  parameter int DEBOUNCE_COUNT_THRESHOLD = 300,
  parameter int SYNC_STAGES              = 2,
  parameter int SATURATE                 = 0,
  parameter int HOLD_CYCLES              = 50_000_000,
  parameter int REPEAT_CYCLES            = 10_000_000
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] count,
  output logic             step_pulse,
  output logic             limit_pulse
);

  // Button lanes: 0 = up, 1 = down, 2 = clr.
  localparam int NB = 3;
  localparam int DW = $clog2(DEBOUNCE_COUNT_THRESHOLD);
  localparam logic [DW-1:0] DB_MAX =
    DW'(DEBOUNCE_COUNT_THRESHOLD - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam bit SAT = (SATURATE != 0);

  logic [NB-1:0]          raw;
  logic [NB-1:0]          sync;
  logic [SYNC_STAGES-1:0] sync_q [NB];
  logic [DW-1:0]          db_cnt [NB];
  logic [NB-1:0]          stable;
  logic [NB-1:0]          stable_d;
  logic [NB-1:0]          press;

  logic ev_up;
  logic ev_down;
  logic ev_clr;

  assign raw = {btn_clr, btn_down, btn_up};

  always_comb begin
    sync = '0;
    for (int b = 0; b < NB; b++) begin
      sync[b] = sync_q[b][SYNC_STAGES-1];
    end
  end

  // Synchroniser, debounce and press detection for all lanes.
  // The debounce counter only advances while the synchronised level
  // disagrees with the accepted level, so any return clears progress.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NB; b++) begin
        sync_q[b] <= '0;
        db_cnt[b] <= '0;
      end
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], raw[b]};
        if (sync[b] == stable[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_MAX) begin
          stable[b] <= sync[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

`ifdef BTN_STEP_COUNTER_AUTOREPEAT_EN

  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] HOLD_END = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RPT_END  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    RP_IDLE,
    RP_HOLD,
    RP_RPT
  } rp_state_t;

  rp_state_t       rp_state;
  logic [RW-1:0]   rp_timer;
  logic            rp_down;
  logic            rep_up;
  logic            rep_down;
  logic            hold_ok;

  // Repeat may only run with exactly one direction held and no clear.
  assign hold_ok = (stable[0] ^ stable[1]) & ~stable[2];

  // Timer starts at 1 on the cycle after the press, so the first
  // repeat pulse lands HOLD_CYCLES after the press pulse.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rp_state <= RP_IDLE;
      rp_timer <= '0;
      rp_down  <= 1'b0;
      rep_up   <= 1'b0;
      rep_down <= 1'b0;
    end else begin
      rep_up   <= 1'b0;
      rep_down <= 1'b0;
      if (!hold_ok) begin
        rp_state <= RP_IDLE;
        rp_timer <= '0;
      end else begin
        unique case (rp_state)
          RP_IDLE: begin
            if (press[0] | press[1]) begin
              rp_state <= RP_HOLD;
              rp_timer <= RW'(1);
              rp_down  <= stable[1];
            end
          end
          RP_HOLD, RP_RPT: begin
            if (rp_down != stable[1]) begin
              rp_state <= RP_IDLE;
              rp_timer <= '0;
            end else if (rp_timer ==
                         ((rp_state == RP_HOLD) ?
                          HOLD_END : RPT_END)) begin
              rep_up   <= ~rp_down;
              rep_down <= rp_down;
              rp_timer <= '0;
              rp_state <= RP_RPT;
            end else begin
              rp_timer <= rp_timer + 1'b1;
            end
          end
          default: begin
            rp_state <= RP_IDLE;
            rp_timer <= '0;
          end
        endcase
      end
    end
  end

  assign ev_up   = press[0] | rep_up;
  assign ev_down = press[1] | rep_down;
  assign ev_clr  = press[2];

`else

  logic unused_cfg;
  assign unused_cfg = (HOLD_CYCLES == REPEAT_CYCLES);

  assign ev_up   = press[0];
  assign ev_down = press[1];
  assign ev_clr  = press[2];

`endif

  // Clear wins, simultaneous up/down cancel, else a single step.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      step_pulse  <= 1'b0;
      limit_pulse <= 1'b0;
    end else begin
      step_pulse  <= 1'b0;
      limit_pulse <= 1'b0;
      if (ev_clr) begin
        count      <= '0;
        step_pulse <= |count;
      end else if (ev_up && ev_down) begin
        count <= count;
      end else if (ev_up) begin
        if (count == CNT_MAX) begin
          limit_pulse <= 1'b1;
          if (!SAT) begin
            count      <= '0;
            step_pulse <= 1'b1;
          end
        end else begin
          count      <= count + 1'b1;
          step_pulse <= 1'b1;
        end
      end else if (ev_down) begin
        if (count == '0) begin
          limit_pulse <= 1'b1;
          if (!SAT) begin
            count      <= CNT_MAX;
            step_pulse <= 1'b1;
          end
        end else begin
          count      <= count - 1'b1;
          step_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_step_counter.sv
// tb_btn_step_counter: directed and randomised checks of btn_step_counter
// in wrap and saturate builds against a history-based reference model.
module tb_btn_step_counter;

  localparam int W  = 4;
  localparam int TH = 4;
  localparam int SY = 2;
  localparam int MAXV = (1 << W) - 1;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic up     = 1'b0;
  logic dn     = 1'b0;
  logic clr    = 1'b0;

  logic [W-1:0] count_w;
  logic [W-1:0] count_s;
  logic step_w, lim_w, step_s, lim_s;

  int n_checks = 0;
  int n_fail   = 0;
  int ns_w = 0, nl_w = 0, ns_s = 0, nl_s = 0;

  always #5 sysclk = ~sysclk;

  btn_step_counter #(
    .WIDTH(W), .DEBOUNCE_COUNT_THRESHOLD(TH),
    .SYNC_STAGES(SY), .SATURATE(0),
    .HOLD_CYCLES(20000), .REPEAT_CYCLES(20000)
  ) dut_w (
    .sysclk(sysclk), .reset_n(rst_n),
    .btn_up(up), .btn_down(dn), .btn_clr(clr),
    .count(count_w), .step_pulse(step_w),
    .limit_pulse(lim_w)
  );

  btn_step_counter #(
    .WIDTH(W), .DEBOUNCE_COUNT_THRESHOLD(TH),
    .SYNC_STAGES(SY), .SATURATE(1),
    .HOLD_CYCLES(20000), .REPEAT_CYCLES(20000)
  ) dut_s (
    .sysclk(sysclk), .reset_n(rst_n),
    .btn_up(up), .btn_down(dn), .btn_clr(clr),
    .count(count_s), .step_pulse(step_s),
    .limit_pulse(lim_s)
  );

`ifdef BTN_STEP_COUNTER_AUTOREPEAT_EN
  logic [W-1:0] count_r;
  logic step_r, lim_r;
  int ns_r = 0;

  btn_step_counter #(
    .WIDTH(W), .DEBOUNCE_COUNT_THRESHOLD(TH),
    .SYNC_STAGES(SY), .SATURATE(0),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(5)
  ) dut_r (
    .sysclk(sysclk), .reset_n(rst_n),
    .btn_up(up), .btn_down(dn), .btn_clr(clr),
    .count(count_r), .step_pulse(step_r),
    .limit_pulse(lim_r)
  );
`endif

  // Pulse tallies, sampled mid-cycle.
  always begin
    @(posedge sysclk);
    #2;
    ns_w += int'(step_w);
    nl_w += int'(lim_w);
    ns_s += int'(step_s);
    nl_s += int'(lim_s);
`ifdef BTN_STEP_COUNTER_AUTOREPEAT_EN
    ns_r += int'(step_r);
`endif
  end

  task automatic clear_obs();
    ns_w = 0; nl_w = 0; ns_s = 0; nl_s = 0;
  endtask

  // Reference model: raw sample history, a debounce window over the
  // synchronised history, and event arithmetic modulo 2^W.
  bit [31:0] rawh  [3];
  bit [31:0] synch [3];
  bit [1:0]  roseh [3];
  bit        m_stable [3];
  int m_cnt_w, m_cnt_s;
  bit m_step_w, m_lim_w, m_step_s, m_lim_s;

  function automatic void model_clear();
    for (int b = 0; b < 3; b++) begin
      rawh[b] = '0; synch[b] = '0;
      roseh[b] = '0; m_stable[b] = 1'b0;
    end
    m_cnt_w = 0; m_cnt_s = 0;
    m_step_w = 0; m_lim_w = 0;
    m_step_s = 0; m_lim_s = 0;
  endfunction

  function automatic void model_apply(
    input bit [2:0] ev, input bit sat, inout int cnt,
    output bit stp, output bit lim);
    stp = 0; lim = 0;
    if (ev[2]) begin
      stp = (cnt != 0);
      cnt = 0;
    end else if (ev[0] != ev[1]) begin
      if (ev[0]) begin
        lim = (cnt == MAXV);
        if (!(sat && lim)) begin
          cnt = (cnt + 1) % (MAXV + 1);
          stp = 1;
        end
      end else begin
        lim = (cnt == 0);
        if (!(sat && lim)) begin
          cnt = (cnt + MAXV) % (MAXV + 1);
          stp = 1;
        end
      end
    end
  endfunction

  function automatic void model_step(input bit [2:0] rawv);
    bit [2:0] ev;
    bit s, rose, diff;
    bit [31:0] mask;
    mask = (32'd1 << TH) - 32'd1;
    for (int b = 0; b < 3; b++) begin
      ev[b] = roseh[b][1];
      s = rawh[b][SY-1];
      rawh[b] = {rawh[b][30:0], rawv[b]};
      synch[b] = {synch[b][30:0], s};
      if (m_stable[b]) diff = ((synch[b] & mask) == 0);
      else diff = ((synch[b] & mask) == mask);
      rose = 0;
      if (diff) begin
        m_stable[b] = !m_stable[b];
        rose = m_stable[b];
      end
      roseh[b] = {roseh[b][0], rose};
    end
    model_apply(ev, 1'b0, m_cnt_w, m_step_w, m_lim_w);
    model_apply(ev, 1'b1, m_cnt_s, m_step_s, m_lim_s);
  endfunction

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else model_step({clr, dn, up});
  end

  task automatic do_reset();
    @(negedge sysclk);
    rst_n = 0; up = 0; dn = 0; clr = 0;
    @(negedge sysclk);
    rst_n = 1;
  endtask

  task automatic press(input bit pu, input bit pd, input bit pc);
    @(negedge sysclk);
    up = pu; dn = pd; clr = pc;
    repeat (10) @(negedge sysclk);
    up = 0; dn = 0; clr = 0;
    repeat (10) @(negedge sysclk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge sysclk);
    n_checks++;
    if (count_w !== '0 || count_s !== '0) begin
      n_fail++;
      $display("FAIL reset_count got %0d/%0d expected 0/0",
               count_w, count_s);
    end
    n_checks++;
    if ({step_w, lim_w, step_s, lim_s} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_pulses got %b expected 0000",
               {step_w, lim_w, step_s, lim_s});
    end
    rst_n = 1;
  endtask

  // Count changes on the 8th rising edge, counting the first one
  // that samples the new level as edge 1.
  task automatic test_latency();
    logic [W-1:0] ec;
    up = 1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge sysclk);
      ec = (e >= 8) ? W'(1) : W'(0);
      n_checks++;
      if (count_w !== ec || step_w !== (e == 8) ||
          lim_w !== 1'b0) begin
        n_fail++;
        $display("FAIL latency edge %0d got c=%0d s=%b l=%b expected c=%0d s=%b l=0",
                 e, count_w, step_w, lim_w, ec, (e == 8));
      end
    end
    up = 0;
    clear_obs();
    repeat (20) @(negedge sysclk);
    n_checks++;
    if (count_w !== W'(1) || ns_w != 0) begin
      n_fail++;
      $display("FAIL release got c=%0d steps=%0d expected c=1 steps=0",
               count_w, ns_w);
    end
  endtask

  task automatic glitches();
    for (int g = 0; g < 6; g++) begin
      up = 1;
      repeat ($urandom_range(1, 3)) @(negedge sysclk);
      up = 0;
      repeat ($urandom_range(1, 2)) @(negedge sysclk);
    end
  endtask

  task automatic test_bounce();
    clear_obs();
    glitches();
    repeat (10) @(negedge sysclk);
    n_checks++;
    if (count_w !== W'(1) || ns_w != 0) begin
      n_fail++;
      $display("FAIL glitch_only got c=%0d steps=%0d expected c=1 steps=0",
               count_w, ns_w);
    end
    glitches();
    up = 1;
    repeat (12) @(negedge sysclk);
    up = 0;
    repeat (12) @(negedge sysclk);
    n_checks++;
    if (count_w !== W'(2) || ns_w != 1) begin
      n_fail++;
      $display("FAIL bounce_hold got c=%0d steps=%0d expected c=2 steps=1",
               count_w, ns_w);
    end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    clear_obs();
    repeat (15) press(1, 0, 0);
    n_checks++;
    if (count_w !== W'(15) || count_s !== W'(15) ||
        ns_w != 15 || nl_w != 0 || nl_s != 0) begin
      n_fail++;
      $display("FAIL fifteen got c=%0d/%0d st=%0d lw=%0d ls=%0d expected 15/15 15 0 0",
               count_w, count_s, ns_w, nl_w, nl_s);
    end
    clear_obs();
    press(1, 0, 0);
    n_checks++;
    if (count_w !== W'(0) || ns_w != 1 || nl_w != 1) begin
      n_fail++;
      $display("FAIL wrap_up got c=%0d st=%0d lim=%0d expected 0 1 1",
               count_w, ns_w, nl_w);
    end
    n_checks++;
    if (count_s !== W'(15) || ns_s != 0 || nl_s != 1) begin
      n_fail++;
      $display("FAIL sat_up got c=%0d st=%0d lim=%0d expected 15 0 1",
               count_s, ns_s, nl_s);
    end
    clear_obs();
    press(0, 1, 0);
    n_checks++;
    if (count_w !== W'(15) || ns_w != 1 || nl_w != 1) begin
      n_fail++;
      $display("FAIL wrap_down got c=%0d st=%0d lim=%0d expected 15 1 1",
               count_w, ns_w, nl_w);
    end
    n_checks++;
    if (count_s !== W'(14) || ns_s != 1 || nl_s != 0) begin
      n_fail++;
      $display("FAIL sat_down got c=%0d st=%0d lim=%0d expected 14 1 0",
               count_s, ns_s, nl_s);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (5) press(1, 0, 0);
    clear_obs();
    press(1, 1, 0);
    n_checks++;
    if (count_w !== W'(5) || ns_w != 0 || nl_w != 0) begin
      n_fail++;
      $display("FAIL up_down got c=%0d st=%0d lim=%0d expected 5 0 0",
               count_w, ns_w, nl_w);
    end
    clear_obs();
    press(1, 1, 1);
    n_checks++;
    if (count_w !== W'(0) || count_s !== W'(0) ||
        ns_w != 1 || nl_w != 0) begin
      n_fail++;
      $display("FAIL clr_all got c=%0d/%0d st=%0d lim=%0d expected 0/0 1 0",
               count_w, count_s, ns_w, nl_w);
    end
    clear_obs();
    press(0, 0, 1);
    n_checks++;
    if (count_w !== W'(0) || ns_w != 0) begin
      n_fail++;
      $display("FAIL clr_zero got c=%0d st=%0d expected 0 0",
               count_w, ns_w);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] ec;
    do_reset();
    repeat (7) press(1, 0, 0);
    n_checks++;
    if (count_w !== W'(7)) begin
      n_fail++;
      $display("FAIL seven got %0d expected 7", count_w);
    end
    @(negedge sysclk);
    dn = 1;
    repeat (4) @(negedge sysclk);
    #2;
    rst_n = 0;
    dn = 0;
    #1;
    n_checks++;
    if (count_w !== W'(0) || step_w !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got c=%0d s=%b expected 0 0",
               count_w, step_w);
    end
    @(negedge sysclk);
    rst_n = 1;
    clear_obs();
    repeat (20) @(negedge sysclk);
    n_checks++;
    if (count_w !== W'(0) || ns_w != 0 || nl_w != 0) begin
      n_fail++;
      $display("FAIL stale_press got c=%0d st=%0d lim=%0d expected 0 0 0",
               count_w, ns_w, nl_w);
    end
    up = 1;
    repeat (3) @(negedge sysclk);
    rst_n = 0;
    @(negedge sysclk);
    rst_n = 1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge sysclk);
      ec = (e >= 8) ? W'(1) : W'(0);
      n_checks++;
      if (count_w !== ec) begin
        n_fail++;
        $display("FAIL held_redebounce edge %0d got %0d expected %0d",
                 e, count_w, ec);
      end
    end
    up = 0;
    repeat (12) @(negedge sysclk);
  endtask

  task automatic test_random();
    int run [3];
    bit [2:0] val;
    run[0] = 0; run[1] = 0; run[2] = 0;
    val = '0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (run[b] == 0) begin
          if (b == 2) val[b] = ($urandom_range(0, 5) == 0);
          else val[b] = $urandom_range(0, 1) != 0;
          run[b] = $urandom_range(1, 12);
        end
        run[b]--;
      end
      up = val[0]; dn = val[1]; clr = val[2];
      rst_n = ($urandom_range(0, 499) != 0);
      @(negedge sysclk);
      n_checks++;
      if (count_w !== W'(m_cnt_w) || step_w !== m_step_w ||
          lim_w !== m_lim_w) begin
        n_fail++;
        $display("FAIL rand_wrap cyc %0d got %0d/%b/%b expected %0d/%b/%b",
                 c, count_w, step_w, lim_w,
                 m_cnt_w, m_step_w, m_lim_w);
      end
      n_checks++;
      if (count_s !== W'(m_cnt_s) || step_s !== m_step_s ||
          lim_s !== m_lim_s) begin
        n_fail++;
        $display("FAIL rand_sat cyc %0d got %0d/%b/%b expected %0d/%b/%b",
                 c, count_s, step_s, lim_s,
                 m_cnt_s, m_step_s, m_lim_s);
      end
    end
    rst_n = 1; up = 0; dn = 0; clr = 0;
    repeat (15) @(negedge sysclk);
  endtask

`ifdef BTN_STEP_COUNTER_AUTOREPEAT_EN
  // Press pulse is in the cycle after edge 7, so steps land on edges
  // 8, 18, 23, ...; raw release after edge 40 drops stable at edge 46.
  task automatic test_autorepeat();
    bit exp_s;
    do_reset();
    ns_r = 0;
    up = 1;
    for (int e = 1; e <= 70; e++) begin
      @(negedge sysclk);
      exp_s = (e == 8 || e == 18 || e == 23 || e == 28 ||
               e == 33 || e == 38 || e == 43);
      n_checks++;
      if (step_r !== exp_s) begin
        n_fail++;
        $display("FAIL repeat_step edge %0d got %b expected %b",
                 e, step_r, exp_s);
      end
      if (e == 40) up = 0;
    end
    n_checks++;
    if (count_r !== W'(7) || ns_r != 7) begin
      n_fail++;
      $display("FAIL repeat_total got c=%0d st=%0d expected 7 7",
               count_r, ns_r);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_latency();
    test_bounce();
    test_wrap_sat();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef BTN_STEP_COUNTER_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
